// File: rtl/gray_fifo_pkg.sv
// Gray-code helpers shared by the pointer counters and the FIFO status decode.
package gray_fifo_pkg;

  // Widest pointer the helpers handle; callers zero-extend in and cast the result back.
  localparam int unsigned FN_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Reflected Gray code back to binary (prefix XOR from the MSB down).
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = int'(FN_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_fifo_if.sv
// Producer/consumer handshake and status bundle for gray_ptr_fifo.
interface gray_ptr_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);

  logic              wrEn;
  logic [DATA_W-1:0] dataIn;
  logic              rdEn;
  logic [DATA_W-1:0] dataOut;
  logic              dataValid;
  logic              full;
  logic              empty;
  logic              almostFull;
  logic              almostEmpty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  // Producer/consumer side.
  modport master (
    output wrEn, dataIn, rdEn,
    input  dataOut, dataValid, full, empty, almostFull, almostEmpty,
           count, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  wrEn, dataIn, rdEn,
    output dataOut, dataValid, full, empty, almostFull, almostEmpty,
           count, overflow, underflow
  );

endinterface

// File: rtl/gray_counter.sv
// Binary up-counter with a registered Gray copy; one Gray bit flips per increment.
module gray_counter
  import gray_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inc,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [WIDTH-1:0] binNext;

  // Successor value; the top wrap back to zero is plain modulo arithmetic.
  always_comb begin
    binNext = bin + WIDTH'(1);
  end

  // Binary and Gray copies advance together so they never disagree.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bin  <= '0;
      gray <= '0;
    end else if (inc) begin
      bin  <= binNext;
      gray <= WIDTH'(bin2gray(FN_W'(binNext)));
    end
  end

endmodule

// File: rtl/gray_ptr_fifo.sv
// Single-clock FIFO with Gray-coded pointers, registered status and sticky error flags.
module gray_ptr_fifo
  import gray_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AF_LEVEL = (1 << ADDR_W) - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic           clk,
  input logic           rstN,
  gray_ptr_fifo_if.slave fifoBus
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  // Full means the Gray pointers differ in exactly their top two bits.
  localparam logic [PTR_W-1:0] FULL_DIFF = PTR_W'(3) << (PTR_W - 2);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wrBin, wrGray, rdBin, rdGray;
  logic [PTR_W-1:0] wrBinNext, rdBinNext, wrGrayNext, rdGrayNext, countNext;
  logic             doWrite, doRead;
  logic             fullNext, emptyNext, almostFullNext, almostEmptyNext;

  logic              fullQ, emptyQ, almostFullQ, almostEmptyQ;
  logic              overflowQ, underflowQ, dataValidQ;
  logic [PTR_W-1:0]  countQ;
  logic [DATA_W-1:0] dataOutQ;

  gray_counter #(.WIDTH(PTR_W)) wrCnt (
    .clk  (clk),
    .rstN (rstN),
    .inc  (doWrite),
    .bin  (wrBin),
    .gray (wrGray)
  );

  gray_counter #(.WIDTH(PTR_W)) rdCnt (
    .clk  (clk),
    .rstN (rstN),
    .inc  (doRead),
    .bin  (rdBin),
    .gray (rdGray)
  );

  // Accept decisions from pre-edge flags, plus post-edge pointers for the registered status.
  always_comb begin
    doWrite    = fifoBus.wrEn && !fullQ;
    doRead     = fifoBus.rdEn && !emptyQ;
    wrBinNext  = wrBin + PTR_W'(doWrite);
    rdBinNext  = rdBin + PTR_W'(doRead);
    wrGrayNext = doWrite ? PTR_W'(bin2gray(FN_W'(wrBinNext))) : wrGray;
    rdGrayNext = doRead  ? PTR_W'(bin2gray(FN_W'(rdBinNext))) : rdGray;
    emptyNext  = (wrGrayNext == rdGrayNext);
    // Also holds for ADDR_W == 1, where the "top two bits" are the whole pointer.
    fullNext        = ((wrGrayNext ^ rdGrayNext) == FULL_DIFF);
    countNext       = wrBinNext - rdBinNext;
    almostFullNext  = (32'(countNext) >= AF_LEVEL);
    almostEmptyNext = (32'(countNext) <= AE_LEVEL);
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wrBin[ADDR_W-1:0]] <= fifoBus.dataIn;
    end
  end

  // Read port: one-cycle latency, holds the last popped word otherwise.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      dataOutQ   <= '0;
      dataValidQ <= 1'b0;
    end else begin
      dataValidQ <= doRead;
      if (doRead) begin
        dataOutQ <= mem[rdBin[ADDR_W-1:0]];
      end
    end
  end

  // Occupancy, flags and sticky errors, all reflecting the state after the edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fullQ        <= 1'b0;
      emptyQ       <= 1'b1;
      almostFullQ  <= (AF_LEVEL == 0);
      almostEmptyQ <= 1'b1;
      countQ       <= '0;
      overflowQ    <= 1'b0;
      underflowQ   <= 1'b0;
    end else begin
      fullQ        <= fullNext;
      emptyQ       <= emptyNext;
      almostFullQ  <= almostFullNext;
      almostEmptyQ <= almostEmptyNext;
      countQ       <= countNext;
      overflowQ    <= overflowQ  | (fifoBus.wrEn && fullQ);
      underflowQ   <= underflowQ | (fifoBus.rdEn && emptyQ);
    end
  end

  assign fifoBus.dataOut     = dataOutQ;
  assign fifoBus.dataValid   = dataValidQ;
  assign fifoBus.full        = fullQ;
  assign fifoBus.empty       = emptyQ;
  assign fifoBus.almostFull  = almostFullQ;
  assign fifoBus.almostEmpty = almostEmptyQ;
  assign fifoBus.count       = countQ;
  assign fifoBus.overflow    = overflowQ;
  assign fifoBus.underflow   = underflowQ;

endmodule

// File: tb/tb_gray_ptr_fifo.sv
// Randomised and directed checks of gray_ptr_fifo against a queue-based model.
module tb_gray_ptr_fifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 7;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rstN = 1'b0;

  always #5 clk = ~clk;

  gray_ptr_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  gray_ptr_fifo #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk     (clk),
    .rstN    (rstN),
    .fifoBus (bus)
  );

  int testCount = 0;
  int failCount = 0;

  logic [DW-1:0] q [$];
  logic          expValid;
  logic [DW-1:0] expOut;
  logic          expOvf;
  logic          expUdf;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    expValid = 1'b0;
    expOut   = '0;
    expOvf   = 1'b0;
    expUdf   = 1'b0;
  endtask

  task automatic checkAll();
    int n;
    n = q.size();
    checkVal("count",       32'(bus.count),       32'(n));
    checkVal("full",        32'(bus.full),        32'(n == DEPTH));
    checkVal("empty",       32'(bus.empty),       32'(n == 0));
    checkVal("almostFull",  32'(bus.almostFull),  32'(n >= AF));
    checkVal("almostEmpty", 32'(bus.almostEmpty), 32'(n <= AE));
    checkVal("overflow",    32'(bus.overflow),    32'(expOvf));
    checkVal("underflow",   32'(bus.underflow),   32'(expUdf));
    checkVal("dataValid",   32'(bus.dataValid),   32'(expValid));
    checkVal("dataOut",     32'(bus.dataOut),     32'(expOut));
  endtask

  // One clock of stimulus, model update and full output check.
  task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d);
    logic [AW:0] prevGray;
    bit          doWr;
    bit          doRd;
    bus.wrEn   = wr;
    bus.rdEn   = rd;
    bus.dataIn = d;
    prevGray   = dut.wrGray;
    doWr = wr && (q.size() < DEPTH);
    doRd = rd && (q.size() > 0);
    if (wr && !doWr) expOvf = 1'b1;
    if (rd && !doRd) expUdf = 1'b1;
    @(posedge clk);
    #1;
    expValid = doRd;
    if (doRd) expOut = q.pop_front();
    if (doWr) q.push_back(d);
    checkAll();
    if (doWr) checkVal("grayStep", 32'($countones(dut.wrGray ^ prevGray)), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] d;
    int pw, pr;
    bus.wrEn   = 1'b0;
    bus.rdEn   = 1'b0;
    bus.dataIn = '0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    checkAll();

    // Fill to full, then one rejected write.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, DW'(i));
    cycle(1'b1, 1'b0, 8'hFF);

    // Drain in order, then one read while empty.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);

    // Steady occupancy of 4 with simultaneous traffic; pointers wrap.
    d = 8'h10;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, d);
      d++;
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, d);
      d++;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);

    // Simultaneous access at full, then at empty.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(8'h40 + i));
    cycle(1'b1, 1'b1, 8'h77);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'h55);
    cycle(1'b0, 1'b1, 8'h00);

    // Asynchronous reset in the middle of a cycle with data in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DW'(8'h30 + i));
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    rstN = 1'b1;
    cycle(1'b1, 1'b0, 8'hAA);
    cycle(1'b0, 1'b1, 8'h00);
    checkVal("firstAfterReset", 32'(bus.dataOut), 32'h0000_00AA);
    cycle(1'b0, 1'b0, 8'h00);

    // Random traffic with shifting write/read bias to visit full and empty.
    for (int blk = 0; blk < 4; blk++) begin
      case (blk)
        0:       begin pw = 75; pr = 30; end
        1:       begin pw = 25; pr = 75; end
        2:       begin pw = 50; pr = 50; end
        default: begin pw = 90; pr = 15; end
      endcase
      for (int i = 0; i < 100; i++) begin
        cycle(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), DW'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
